// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Raises miss for the hazard unit and bursts whole lines to/from memory over req/ack.
module dcache_ctrl #(
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              miss,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);
    localparam logic [OFF_W-1:0] BEAT_ZERO = {OFF_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t           state_r;
    logic [LINES-1:0] valid_r;
    logic [LINES-1:0] dirty_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [31:0]      data_r [LINES*WORDS];
    logic [OFF_W-1:0] beat_r;

    logic [OFF_W-1:0] off_s;
    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic             access_s;
    logic             hit_s;
    logic             ack_s;
    logic [OFF_W-1:0] beat_nxt_s;
    logic             addr_unused_s;

    assign off_s         = cpu_addr[OFF_W+1:2];
    assign idx_s         = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign tag_s         = cpu_addr[ADDR_W-1:OFF_W+IDX_W+2];
    assign addr_unused_s = ^cpu_addr[1:0];

    // Hit detection, stall request and zero-latency load data.
    always_comb begin
        access_s   = cpu_rd | cpu_wr;
        hit_s      = access_s & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
        miss       = (state_r != IDLE) | (access_s & ~hit_s);
        ack_s      = mem_ack & mem_req;
        beat_nxt_s = beat_r + OFF_W'(1);
        if (access_s) begin
            cpu_rdata = data_r[{idx_s, off_s}];
        end else begin
            cpu_rdata = 32'd0;
        end
    end

    // Control FSM: line state, beat counter and the registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            valid_r   <= {LINES{1'b0}};
            dirty_r   <= {LINES{1'b0}};
            beat_r    <= BEAT_ZERO;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hit_s) begin
                        if (cpu_wr) dirty_r[idx_s] <= 1'b1;
                    end else if (access_s) begin
                        beat_r  <= BEAT_ZERO;
                        mem_req <= 1'b1;
                        if (valid_r[idx_s] && dirty_r[idx_s]) begin
                            state_r   <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_r[idx_s], idx_s, BEAT_ZERO, 2'b00};
                            mem_wdata <= data_r[{idx_s, BEAT_ZERO}];
                        end else begin
                            // The line is rewritten beat by beat, so it must not hit meanwhile.
                            state_r        <= REFILL;
                            valid_r[idx_s] <= 1'b0;
                            mem_we         <= 1'b0;
                            mem_addr       <= {tag_s, idx_s, BEAT_ZERO, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (ack_s) begin
                        if (beat_r == LAST_BEAT) begin
                            state_r        <= REFILL;
                            valid_r[idx_s] <= 1'b0;
                            beat_r         <= BEAT_ZERO;
                            mem_we         <= 1'b0;
                            mem_addr       <= {tag_s, idx_s, BEAT_ZERO, 2'b00};
                        end else begin
                            beat_r    <= beat_nxt_s;
                            mem_addr  <= {tag_r[idx_s], idx_s, beat_nxt_s, 2'b00};
                            mem_wdata <= data_r[{idx_s, beat_nxt_s}];
                        end
                    end
                end
                REFILL: begin
                    if (ack_s) begin
                        if (beat_r == LAST_BEAT) begin
                            state_r        <= IDLE;
                            beat_r         <= BEAT_ZERO;
                            mem_req        <= 1'b0;
                            valid_r[idx_s] <= 1'b1;
                            dirty_r[idx_s] <= 1'b0;
                            tag_r[idx_s]   <= tag_s;
                        end else begin
                            beat_r   <= beat_nxt_s;
                            mem_addr <= {tag_s, idx_s, beat_nxt_s, 2'b00};
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Line data array: store hits and refill beats; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && state_r == IDLE && hit_s && cpu_wr) begin
            data_r[{idx_s, off_s}] <= cpu_wdata;
        end else if (!rst && state_r == REFILL && ack_s) begin
            data_r[{idx_s, beat_r}] <= mem_rdata;
        end
    end
endmodule
